// File: rtl/spi_blk_tx_seq_pkg.sv
// spi_blk_tx_seq_pkg: shared state encoding and token constants for the SD block-write sequencer
package spi_blk_tx_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_FETCH, S_DATA, S_CRC, S_DONE} state_t;
   localparam logic [7:0] TOKEN_SINGLE = 8'hFE;
   localparam logic [7:0] TOKEN_MULTI = 8'hFC;
   localparam int CRC_BITS = 16;
endpackage

// File: rtl/spi_tx_byte_shreg.sv
// spi_tx_byte_shreg: 8-bit MSB-first load/shift register with a bit index and last-bit flag
module spi_tx_byte_shreg (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       shift,
   output logic       msb,
   output logic       last
);
   logic [7:0] sh;
   logic [2:0] idx;
   // load a fresh byte at index 7, or move the next bit into the MSB position
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh  <= '0;
         idx <= '0;
      end else if (load) begin
         sh  <= din;
         idx <= 3'd7;
      end else if (shift) begin
         sh  <= {sh[6:0], 1'b0};
         idx <= idx - 3'd1;
      end
   assign msb = sh[7];
   assign last = idx == 3'd0;
endmodule

// File: rtl/spi_blk_tx_seq.sv
// spi_blk_tx_seq: sends start token, data block and CRC16 on sdo, steering the external CRC generator
module spi_blk_tx_seq
   import spi_blk_tx_seq_pkg::*;
#(
   parameter int BLK_BYTES = 512,
   parameter int BYTE_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       multi,
   input  logic       abort,
   input  logic       bit_tick,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       sdo,
   output logic       sdo_oe,
   output logic       busy,
   output logic       done,
   output logic       underrun,
   output logic       crc_load_start_tkn,
   output logic       crc_load_multi_blk_wr_tkn,
   output logic       crc_gen_en,
   output logic       crc_out_en,
   output logic       crc_din,
   input  logic       crc_dout
);
   state_t state, nxt;
   logic sh_load, sh_shift, sh_msb, sh_last, last_bit, last_byte;
   logic [7:0] sh_din;
   logic [BYTE_W-1:0] byte_cnt;
   logic [3:0] crc_cnt;
   assign busy = state != S_IDLE;
   assign last_byte = byte_cnt == BYTE_W'(BLK_BYTES - 1);
   // the token is loaded into the byte shifter on start, so it doubles as the latched multi flag
   assign sh_din = state == S_IDLE ? (multi ? TOKEN_MULTI : TOKEN_SINGLE) : byte_data;
   spi_tx_byte_shreg u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (sh_load),
      .din   (sh_din),
      .shift (sh_shift),
      .msb   (sh_msb),
      .last  (sh_last)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= nxt;
   // next state and outputs; abort overrides every strobe and forces IDLE
   always_comb begin
      nxt = state;
      sdo = 1'b1;
      sdo_oe = 1'b0;
      byte_ready = 1'b0;
      done = 1'b0;
      crc_load_start_tkn = 1'b0;
      crc_load_multi_blk_wr_tkn = 1'b0;
      crc_gen_en = 1'b0;
      crc_out_en = 1'b0;
      crc_din = 1'b0;
      sh_load = 1'b0;
      sh_shift = 1'b0;
      case (state)
         S_IDLE: if (start) begin
            crc_load_start_tkn = !multi;
            crc_load_multi_blk_wr_tkn = multi;
            sh_load = 1'b1;
            nxt = S_TOKEN;
         end
         S_TOKEN: begin
            sdo = sh_msb;
            sdo_oe = 1'b1;
            sh_shift = bit_tick;
            if (bit_tick && sh_last) nxt = S_FETCH;
         end
         S_FETCH: begin
            sdo = last_bit;
            sdo_oe = 1'b1;
            byte_ready = byte_valid;
            sh_load = byte_valid;
            if (byte_valid) nxt = S_DATA;
         end
         S_DATA: begin
            sdo = sh_msb;
            sdo_oe = 1'b1;
            crc_din = sh_msb;
            crc_gen_en = bit_tick;
            sh_shift = bit_tick;
            if (bit_tick && sh_last) nxt = last_byte ? S_CRC : S_FETCH;
         end
         S_CRC: begin
            sdo = crc_dout;
            sdo_oe = 1'b1;
            crc_out_en = bit_tick;
            if (bit_tick && crc_cnt == 4'd0) nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
      if (abort) begin
         nxt = S_IDLE;
         byte_ready = 1'b0;
         done = 1'b0;
         crc_load_start_tkn = 1'b0;
         crc_load_multi_blk_wr_tkn = 1'b0;
         crc_gen_en = 1'b0;
         crc_out_en = 1'b0;
         sh_load = 1'b0;
         sh_shift = 1'b0;
      end
   end
   // byte/CRC counters, sticky underrun and the last sent bit held on sdo while fetching
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         byte_cnt <= '0;
         crc_cnt <= '0;
         underrun <= 1'b0;
         last_bit <= 1'b1;
      end else if (abort) begin
         byte_cnt <= '0;
         crc_cnt <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            underrun <= 1'b0;
            byte_cnt <= '0;
         end
         if (state == S_FETCH && bit_tick && !byte_valid) underrun <= 1'b1;
         if (state == S_DATA && bit_tick && sh_last) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + BYTE_W'(1);
            crc_cnt <= 4'(CRC_BITS - 1);
         end
         if (state == S_CRC && bit_tick) crc_cnt <= crc_cnt - 4'd1;
         if (sh_shift) last_bit <= sh_msb;
      end
endmodule

// File: tb/tb_spi_blk_tx_seq.sv
// tb_spi_blk_tx_seq: scoreboard bench for the SD block-write sequencer with a behavioural CRC16 generator
module tb_spi_blk_tx_seq;
   localparam int BLK = 4;
   localparam int NBITS = 8 + 8 * BLK + 16;
   typedef struct {
      logic        m;
      logic [31:0] d;
      int          stall;
      logic        und;
   } vec_t;
   vec_t vecs [5];
   logic clk = 0, rst = 1, start = 0, multi = 0, abort = 0, bit_tick = 0, byte_valid = 0;
   logic [7:0] byte_data = 8'h00;
   logic byte_ready, sdo, sdo_oe, busy, done, underrun, ld_s, ld_m, gen_en, out_en, crc_din, crc_dout;
   logic [15:0] crc_reg;
   logic exp_q [$];
   logic [7:0] feed_q [$];
   int n_tests = 0, n_fail = 0;
   int n_gen = 0, n_out = 0, n_lds = 0, n_ldm = 0, n_done = 0, n_tick = 0;
   int bits_seen = 0, stall_ticks = 0, popped = 0, stall_idx = -1;
   int b_gen, b_out, b_lds, b_ldm, b_done, b_tick;

   spi_blk_tx_seq #(.BLK_BYTES(BLK), .BYTE_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .multi(multi), .abort(abort), .bit_tick(bit_tick),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready), .sdo(sdo),
      .sdo_oe(sdo_oe), .busy(busy), .done(done), .underrun(underrun),
      .crc_load_start_tkn(ld_s), .crc_load_multi_blk_wr_tkn(ld_m), .crc_gen_en(gen_en),
      .crc_out_en(out_en), .crc_din(crc_din), .crc_dout(crc_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      for (int i = 7; i >= 0; i--) c = crc_step(c, d[i]);
      return c;
   endfunction

   // behavioural CRC16 (x^16+x^12+x^5+1) generator driven by the DUT's strobes
   always @(posedge clk or posedge rst)
      if (rst) crc_reg <= 16'h0000;
      else if (ld_s) crc_reg <= crc_byte(16'h0000, 8'hFE);
      else if (ld_m) crc_reg <= crc_byte(16'h0000, 8'hFC);
      else if (gen_en) crc_reg <= crc_step(crc_reg, crc_din);
      else if (out_en) crc_reg <= {crc_reg[14:0], 1'b0};
   assign crc_dout = crc_reg[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: strobe counters and the scoreboard of sdo bits
   always @(negedge clk) begin
      if (start && !busy && !abort && !rst) begin
         bits_seen = 0;
         stall_ticks = 0;
      end
      if (gen_en) n_gen++;
      if (out_en) n_out++;
      if (ld_s) n_lds++;
      if (ld_m) n_ldm++;
      if (done) n_done++;
      if (bit_tick && busy) n_tick++;
      if (bit_tick && sdo_oe) begin
         if (popped == stall_idx && bits_seen == 8 + 8 * stall_idx && stall_ticks < 3) stall_ticks++;
         else if (exp_q.size() == 0) chk("sdo_extra_bit", 32'd0, 32'd1);
         else begin
            chk("sdo_bit", 32'(sdo), 32'(exp_q.pop_front()));
            bits_seen++;
         end
      end
   end

   // upstream byte source, optionally withholding one byte for three ticks
   initial begin : feeder
      logic acc;
      forever begin
         @(negedge clk);
         acc = byte_ready;
         if (start && !busy && !abort && !rst) popped = 0;
         @(posedge clk);
         #1;
         if (acc && feed_q.size() > 0) begin
            void'(feed_q.pop_front());
            popped++;
         end
         byte_valid = feed_q.size() > 0 && !(popped == stall_idx && stall_ticks < 3);
         byte_data = feed_q.size() > 0 ? feed_q[0] : 8'h00;
      end
   end

   // pad shifter model: one bit_tick every 4 clk
   initial forever begin
      repeat (3) @(posedge clk);
      #1 bit_tick = 1'b1;
      @(posedge clk);
      #1 bit_tick = 1'b0;
   end

   task automatic flush();
      exp_q.delete();
      feed_q.delete();
   endtask

   task automatic wait_bits(input int n);
      int t = 0;
      while (bits_seen < n && t < 5000) begin
         @(posedge clk);
         t++;
      end
      chk("wait_bits_reached", 32'(bits_seen >= n), 32'd1);
   endtask

   task automatic begin_block(input logic m, input logic [31:0] d, input int st);
      logic [15:0] c;
      logic [7:0] tok, b;
      tok = m ? 8'hFC : 8'hFE;
      c = crc_byte(16'h0000, tok);
      for (int i = 7; i >= 0; i--) exp_q.push_back(tok[i]);
      for (int k = 0; k < BLK; k++) begin
         b = d[31 - 8 * k -: 8];
         feed_q.push_back(b);
         for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
         c = crc_byte(c, b);
      end
      for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
      stall_idx = st;
      b_gen = n_gen; b_out = n_out; b_lds = n_lds; b_ldm = n_ldm; b_done = n_done; b_tick = n_tick;
      @(posedge clk);
      #2 multi = m; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0; multi = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic end_block(input logic m, input logic und, input int stalls);
      int t = 0;
      while (n_done == b_done && t < 4000) begin
         @(posedge clk);
         t++;
      end
      @(negedge clk);
      chk("done_pulses", 32'(n_done - b_done), 32'd1);
      chk("idle_after_done", {29'd0, busy, sdo_oe, sdo}, 32'd1);
      chk("crc_gen_en_count", 32'(n_gen - b_gen), 32'(8 * BLK));
      chk("crc_out_en_count", 32'(n_out - b_out), 32'd16);
      chk("load_start_count", 32'(n_lds - b_lds), 32'(!m));
      chk("load_multi_count", 32'(n_ldm - b_ldm), 32'(m));
      chk("ticks_while_busy", 32'(n_tick - b_tick), 32'(NBITS + stalls));
      chk("bits_sent", 32'(bits_seen), 32'(NBITS));
      chk("bits_left", 32'(exp_q.size()), 32'd0);
      chk("underrun", 32'(underrun), 32'(und));
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h01020304, -1, 1'b0};
      vecs[1] = '{1'b1, 32'h01020304, -1, 1'b0};
      vecs[2] = '{1'b0, 32'hA55AFF00, 1, 1'b1};
      vecs[3] = '{1'b1, 32'h807FC33C, -1, 1'b0};
      vecs[4] = '{1'b0, 32'h00000000, -1, 1'b0};
      repeat (2) @(posedge clk);
      #1 chk("reset_outs", {21'd0, sdo, sdo_oe, busy, done, underrun, byte_ready, ld_s, ld_m, gen_en, out_en, crc_din}, 32'h400);
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         begin_block(vecs[i].m, vecs[i].d, vecs[i].stall);
         end_block(vecs[i].m, vecs[i].und, vecs[i].stall >= 0 ? 3 : 0);
      end
      // abort in the middle of data bit 13
      begin_block(1'b0, 32'h11223344, -1);
      wait_bits(8 + 13);
      @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      chk("abort_idle", {29'd0, busy, sdo_oe, sdo}, 32'd1);
      flush();
      repeat (30) @(posedge clk);
      chk("abort_no_done", 32'(n_done - b_done), 32'd0);
      chk("abort_stays_idle", 32'(busy), 32'd0);
      begin_block(1'b0, 32'h01020304, -1);
      end_block(1'b0, 1'b0, 0);
      // asynchronous reset during the CRC phase
      begin_block(1'b1, 32'hDEADBEEF, -1);
      wait_bits(8 + 8 * BLK + 5);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_async_outs", {21'd0, sdo, sdo_oe, busy, done, underrun, byte_ready, ld_s, ld_m, gen_en, out_en, crc_din}, 32'h400);
      flush();
      @(posedge clk);
      #2 rst = 1'b0;
      begin_block(1'b1, 32'hCAFE0001, -1);
      end_block(1'b1, 1'b0, 0);
      // start while busy must not disturb the running block
      begin_block(1'b0, 32'h0F1E2D3C, -1);
      wait_bits(8 + 10);
      @(posedge clk);
      #2 start = 1'b1; multi = 1'b1;
      @(posedge clk);
      #2 start = 1'b0; multi = 1'b0;
      end_block(1'b0, 1'b0, 0);
      // start together with abort while busy: abort wins, no new block
      begin_block(1'b0, 32'h55AA55AA, -1);
      wait_bits(8 + 5);
      @(posedge clk);
      #2 start = 1'b1; abort = 1'b1; multi = 1'b1;
      @(posedge clk);
      #2 start = 1'b0; abort = 1'b0; multi = 1'b0;
      chk("start_abort_idle", 32'(busy), 32'd0);
      flush();
      repeat (20) @(posedge clk);
      chk("start_abort_stays_idle", 32'(busy), 32'd0);
      chk("start_abort_lds", 32'(n_lds - b_lds), 32'd1);
      chk("start_abort_ldm", 32'(n_ldm - b_ldm), 32'd0);
      chk("start_abort_no_done", 32'(n_done - b_done), 32'd0);
      begin_block(1'b0, 32'h01020304, -1);
      end_block(1'b0, 1'b0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
